bcd_display_scanner: RTL and testbench
======================================

# bcd_display_scanner

Time-multiplexed seven-segment driver that consumes the BCD digit outputs (and carry-out) of a chain of BCD counters and drives a common-anode multi-digit display. Captures a snapshot of the counter digits on a strobe, scans one digit per refresh slot, blanks leading zeros on request, and shows a sticky overflow flag on the most significant digit's decimal point. Sits directly downstream of the BCD counter stage, between its `Q`/`CO` outputs and the board display pins.

## Interface

Parameters:
- `DIGITS`, 4: number of BCD digits scanned; legal range 2..8.
- `PRESCALE`, 50000: CLK cycles per digit slot; legal minimum 2.

Ports:
- `CLK`  input  1  system clock; the only clock; all state updates on its rising edge.
- `CLR`  input  1  reset, asynchronous, active-high.
- `BCD_IN`  input  4*DIGITS  packed digits; `[3:0]` is the least significant digit.
- `LATCH`  input  1  capture strobe; copies `BCD_IN` into the shadow register.
- `CO_IN`  input  1  carry-out from the most significant counter; sets the overflow flag.
- `OVF_CLR`  input  1  synchronous clear of the overflow flag.
- `BLANK_LZ`  input  1  leading-zero blanking enable.
- `SEG`  output  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `DP`  output  1  decimal point, active-low.
- `AN`  output  DIGITS  digit anodes, one-hot active-low.
- `SCAN_TICK`  output  1  one-cycle pulse per digit slot.

## Operation

- Shadow register: on an edge with `LATCH`=1, shadow <= `BCD_IN`. The display reads only the shadow, so no tearing occurs mid-scan.
- Prescaler counts 0..PRESCALE-1, then wraps to 0. On the edge where the count is PRESCALE-1, the digit index advances, wrapping DIGITS-1 -> 0.
- Decode, active-low `{g..a}`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Invalid codes 10..15 show a dash, 0111111.
  - Blank is 1111111.
- Leading-zero blanking (`BLANK_LZ`=1): digit i is blanked iff it and every digit above it are 0. Digit 0 is never blanked. Invalid codes count as nonzero.
- Overflow flag:
  - Set on an edge with `CO_IN`=1.
  - Cleared on an edge with `OVF_CLR`=1 and `CO_IN`=0; when both are high, set wins.
  - `DP` is 0 only while the flag is set and index = DIGITS-1; otherwise `DP` is 1.
  - `DP` is independent of blanking.
- `AN[i]`=0 iff the registered index = i.

## Timing

- Reset values:
  - Prescaler 0, index 0, shadow all 0, overflow flag 0.
  - `SEG`=1111111, `DP`=1, `AN`=all 1s, `SCAN_TICK`=0.
- `SEG`/`DP`/`AN` are registered and reflect the index held during the previous cycle. After reset release they show digit 0 from the first edge.
- Index advances at edge E (prescaler = PRESCALE-1). `SCAN_TICK`=1 for exactly the cycle following E. `AN`/`SEG` show the new digit from edge E+1.
- `LATCH` at edge N: shadow is updated at N. The new value appears on `SEG` from N+1 whenever that digit is selected.
- `OVF_CLR`/`CO_IN` at edge N: `DP` changes from edge N+1, if the MS digit is selected.
- Asserting `CLR` mid-scan forces all reset values immediately and asynchronously. Scanning restarts at digit 0 with a full PRESCALE slot.
- Digit slot period is exactly PRESCALE cycles. Full frame is DIGITS*PRESCALE cycles.

## Structure

- Package `bcd_display_pkg`:
  - Segment pattern constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`.
  - Default `DIGITS` and `PRESCALE`.
- Sub-module `bcd_to_7seg`: combinational, 4-bit code plus blank input -> 7-bit active-low pattern. One instance, fed from the index-selected shadow digit.
- Top module holds the prescaler, index, shadow, overflow flag, leading-zero logic and output registers.

## Test plan

Use `DIGITS`=4, `PRESCALE`=4.
1. Reset:
   - During `CLR`=1: `AN`=1111, `SEG`=1111111, `DP`=1, `SCAN_TICK`=0.
   - After release: `AN` walks 1110 -> 1101 -> 1011 -> 0111 -> 1110, each held 4 cycles.
   - `SCAN_TICK` pulses every 4 cycles.
2. Latch and decode:
   - Stimulus: `BCD_IN`=16'h9405, `LATCH` pulse.
   - Required over one frame: digit 0 `SEG`=0010010, digit 1 1000000, digit 2 0011001, digit 3 0010000.
   - Changing `BCD_IN` without `LATCH` leaves the display unchanged.
3. Leading-zero blanking:
   - `BCD_IN`=16'h0040, `BLANK_LZ`=1: digits 3 and 2 show 1111111; digit 1 shows 0011001; digit 0 shows 1000000.
   - `BCD_IN`=16'h0000: only digit 0 is lit, showing 1000000.
4. Invalid digit:
   - `BCD_IN`=16'h00A3, `BLANK_LZ`=1: digit 1 shows 0111111; digits 3 and 2 are blank.
5. Overflow:
   - One-cycle `CO_IN` pulse: `DP`=0 only in digit-3 slots, repeated across frames.
   - `OVF_CLR` and `CO_IN` asserted together: the flag stays set.
   - `OVF_CLR` alone: `DP`=1 from the next edge.
6. Reset mid-scan:
   - Assert `CLR` in the digit-2 slot with the flag set: outputs go to reset values immediately.
   - After release: the scan resumes at digit 0, the flag is clear, and the shadow reads 0.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared defaults and active-low {g,f,e,d,c,b,a} segment
// patterns for the multiplexed BCD display scanner.
`default_nettype none

package bcd_display_pkg;

  localparam int DEFAULT_DIGITS   = 4;
  localparam int DEFAULT_PRESCALE = 50000;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-low seven-segment decoder with
// blanking; codes 10..15 are shown as a dash.
`default_nettype none

module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: snapshots BCD counter digits and scans them onto a
// common-anode display, with leading-zero blanking and a sticky overflow DP.
`default_nettype none

module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int DIGITS   = DEFAULT_DIGITS,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [4*DIGITS-1:0] BCD_IN,
  input  logic                LATCH,
  input  logic                CO_IN,
  input  logic                OVF_CLR,
  input  logic                BLANK_LZ,
  output logic [6:0]          SEG,
  output logic                DP,
  output logic [DIGITS-1:0]   AN,
  output logic                SCAN_TICK
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PS_MAX  = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [PW-1:0]         prescale, prescale_nxt;
  logic [IW-1:0]         index, index_nxt;
  logic [4*DIGITS-1:0]   shadow, shadow_nxt;
  logic                  ovf, ovf_nxt;
  logic                  slot_end;
  logic [3:0]            digit [DIGITS];
  logic [DIGITS-1:0]     blank_mask;
  logic                  zero_run;
  logic [DIGITS-1:0]     an_nxt;
  logic [6:0]            seg_nxt;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [DIGITS-1:0]     an_q;
  logic                  tick_q;

  always_comb begin
    slot_end     = (prescale == PS_MAX);
    prescale_nxt = slot_end ? '0 : prescale + PW'(1);
    index_nxt    = index;
    if (slot_end) begin
      index_nxt = (index == IDX_MAX) ? '0 : index + IW'(1);
    end
    // CO_IN takes priority so a carry arriving with a clear is never lost.
    ovf_nxt    = CO_IN ? 1'b1 : (OVF_CLR ? 1'b0 : ovf);
    shadow_nxt = LATCH ? BCD_IN : shadow;
    for (int i = 0; i < DIGITS; i++) begin
      digit[i]  = shadow[4*i +: 4];
      an_nxt[i] = (index != IW'(i));
    end
  end

  // Walk down from the MS digit; a digit blanks only while every digit at or
  // above it is zero. Digit 0 is excluded so a zero value still shows "0".
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (digit[i] == 4'd0);
      blank_mask[i] = BLANK_LZ && zero_run;
    end
  end

  bcd_to_7seg u_dec (
    .code  (digit[index]),
    .blank (blank_mask[index]),
    .seg   (seg_nxt)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      prescale <= '0;
      index    <= '0;
      shadow   <= '0;
      ovf      <= 1'b0;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      prescale <= prescale_nxt;
      index    <= index_nxt;
      shadow   <= shadow_nxt;
      ovf      <= ovf_nxt;
      seg_q    <= seg_nxt;
      dp_q     <= ~(ovf && (index == IDX_MAX));
      an_q     <= an_nxt;
      tick_q   <= slot_end;
    end
  end

  assign SEG       = seg_q;
  assign DP        = dp_q;
  assign AN        = an_q;
  assign SCAN_TICK = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed self-checking bench for a 4-digit scanner
// with a 4-cycle digit slot.
`default_nettype none

module tb_bcd_display_scanner;

  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_3     = 7'b0110000;
  localparam logic [6:0] S_4     = 7'b0011001;
  localparam logic [6:0] S_5     = 7'b0010010;
  localparam logic [6:0] S_9     = 7'b0010000;
  localparam logic [6:0] S_DASH  = 7'b0111111;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] bcd_in;
  logic        latch;
  logic        co_in;
  logic        ovf_clr;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        scan_tick;

  int compared   = 0;
  int mismatched = 0;

  bcd_display_scanner #(
    .DIGITS   (4),
    .PRESCALE (4)
  ) dut (
    .CLK       (clk),
    .CLR       (clr),
    .BCD_IN    (bcd_in),
    .LATCH     (latch),
    .CO_IN     (co_in),
    .OVF_CLR   (ovf_clr),
    .BLANK_LZ  (blank_lz),
    .SEG       (seg),
    .DP        (dp),
    .AN        (an),
    .SCAN_TICK (scan_tick)
  );

  always #5 clk = ~clk;

  task automatic check_seg(input string tag, input logic [6:0] exp);
    compared++;
    assert (seg === exp) else begin
      mismatched++;
      $error("FAIL %s: SEG observed %b expected %b", tag, seg, exp);
    end
  endtask

  task automatic check_an(input string tag, input logic [3:0] exp);
    compared++;
    assert (an === exp) else begin
      mismatched++;
      $error("FAIL %s: AN observed %b expected %b", tag, an, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Step at least one cycle, then until digit d is selected (bounded).
  task automatic wait_digit(input int d);
    logic [3:0] target;
    int n;
    target = ~(4'b0001 << d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== target && n < 24);
    check_an($sformatf("reach_digit%0d", d), target);
  endtask

  task automatic load(input logic [15:0] value);
    @(negedge clk);
    bcd_in = value;
    latch  = 1'b1;
    @(negedge clk);
    latch  = 1'b0;
  endtask

  task automatic pulse_co(input logic with_clr);
    @(negedge clk);
    co_in   = 1'b1;
    ovf_clr = with_clr;
    @(negedge clk);
    co_in   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; bcd_in = '0; latch = 1'b0; co_in = 1'b0;
    ovf_clr = 1'b0; blank_lz = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_an("rst_an", 4'b1111);
    check_seg("rst_seg", S_BLANK);
    check_bit("rst_dp", dp, 1'b1);
    check_bit("rst_tick", scan_tick, 1'b0);

    // Anode walk and tick cadence right after release.
    clr = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check_an($sformatf("walk_an_%0d", k), ~(4'b0001 << (((k - 1) / 4) % 4)));
      check_bit($sformatf("walk_tick_%0d", k), scan_tick, (k % 4) == 0);
      if (k == 1) check_seg("walk_seg_first", S_0);
    end

    // Latch and decode.
    load(16'h9405);
    wait_digit(0); check_seg("dec_d0", S_5);
    wait_digit(1); check_seg("dec_d1", S_0);
    wait_digit(2); check_seg("dec_d2", S_4);
    wait_digit(3); check_seg("dec_d3", S_9);
    bcd_in = 16'h1234;
    wait_digit(0); check_seg("nolatch_d0", S_5);
    wait_digit(3); check_seg("nolatch_d3", S_9);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load(16'h0040);
    wait_digit(0); check_seg("lz40_d0", S_0);
    wait_digit(1); check_seg("lz40_d1", S_4);
    wait_digit(2); check_seg("lz40_d2", S_BLANK);
    wait_digit(3); check_seg("lz40_d3", S_BLANK);
    load(16'h0000);
    wait_digit(0); check_seg("lz00_d0", S_0);
    wait_digit(1); check_seg("lz00_d1", S_BLANK);
    wait_digit(2); check_seg("lz00_d2", S_BLANK);
    wait_digit(3); check_seg("lz00_d3", S_BLANK);

    // Invalid code counts as nonzero and shows a dash.
    load(16'h00A3);
    wait_digit(0); check_seg("inv_d0", S_3);
    wait_digit(1); check_seg("inv_d1", S_DASH);
    wait_digit(2); check_seg("inv_d2", S_BLANK);
    wait_digit(3); check_seg("inv_d3", S_BLANK);

    // Overflow flag on the MS digit decimal point, over two frames.
    pulse_co(1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < 4; d++) begin
        wait_digit(d);
        check_bit($sformatf("ovf_f%0d_d%0d", f, d), dp, d != 3);
      end
    end
    pulse_co(1'b1);
    wait_digit(3); check_bit("ovf_both_d3", dp, 1'b0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    wait_digit(3); check_bit("ovfclr_d3", dp, 1'b1);
    wait_digit(0); check_bit("ovfclr_d0", dp, 1'b1);

    // Reset mid-scan with the flag set.
    pulse_co(1'b0);
    wait_digit(3); check_bit("pre_rst_dp", dp, 1'b0);
    wait_digit(2);
    clr = 1'b1;
    #1;
    check_an("mid_rst_an", 4'b1111);
    check_seg("mid_rst_seg", S_BLANK);
    check_bit("mid_rst_dp", dp, 1'b1);
    check_bit("mid_rst_tick", scan_tick, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_an($sformatf("resume_an_%0d", k), (k <= 4) ? 4'b1110 : 4'b1101);
      if (k == 1) check_seg("resume_seg_d0", S_0);
    end
    wait_digit(3);
    check_bit("resume_dp_d3", dp, 1'b1);
    check_seg("resume_seg_d3", S_BLANK);
    blank_lz = 1'b0;
    wait_digit(1); check_seg("resume_shadow_d1", S_0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
